// File: rtl/comp_conv_arb.sv
// Round-robin arbiter sharing one sign-magnitude to two's-complement converter among N_REQ requesters.
// Define COMP_CONV_ARB_NZ_FIX_EN to map negative zero to 0.
module comp_conv_arb #(
    parameter int unsigned W     = 8,
    parameter int unsigned N_REQ = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] data_in,
    output logic [N_REQ-1:0]   grant,
    output logic               out_valid,
    output logic [W-1:0]       out_data,
    output logic [ID_W-1:0]    out_id,
    input  logic               out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [ID_W-1:0]  out_id_q, out_id_d;

    logic             found_hi, found_any;
    logic [ID_W-1:0]  win_hi, win_lo, win;
    logic [W-1:0]     win_word;

    function automatic logic [W-1:0] conv(input logic [W-1:0] x);
        logic [W-2:0] mag;
        mag = ~x[W-2:0] + 1'b1;
        if (!x[W-1]) begin
            return x;
        end
`ifdef COMP_CONV_ARB_NZ_FIX_EN
        if (x[W-2:0] == '0) begin
            return '0;
        end
`endif
        return {1'b1, mag};
    endfunction

    // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        found_hi  = 1'b0;
        found_any = 1'b0;
        win_hi    = '0;
        win_lo    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found_any = 1'b1;
                win_lo    = ID_W'(i);
                if (i >= int'(32'(ptr_q))) begin
                    found_hi = 1'b1;
                    win_hi   = ID_W'(i);
                end
            end
        end
        win = found_hi ? win_hi : win_lo;
    end

    always_comb begin
        win_word = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (ID_W'(i) == win) begin
                win_word = data_in[i*W +: W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = '0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        case (state_q)
            IDLE: begin
                if (found_any) begin
                    out_data_d  = conv(win_word);
                    out_id_d    = win;
                    grant_d     = N_REQ'(1) << win;
                    out_valid_d = 1'b1;
                    state_d     = HOLD;
                    ptr_d       = (32'(win) == N_REQ - 1) ? '0 : win + 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
        end
    end

    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;

endmodule

// File: tb/tb_comp_conv_arb.sv
// Self-checking bench for comp_conv_arb: vector table plus hand sequences, grants scored from a queue.
module tb_comp_conv_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  grant;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_id;
    logic        out_ready;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] words;
        logic [1:0]  id;
        logic [7:0]  data;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   checks = 0;
    int   failures = 0;
    logic spacing_chk = 1'b0;
    int   cyc = 0;
    int   last_grant_cyc = 0;
    int   win_n = 0;
    logic [7:0] nz_exp;

    comp_conv_arb #(.W(8), .N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_in   (data_in),
        .grant     (grant),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic wait_sb_empty(input int max_cyc);
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        chk("sb_drain", 32'(sb.size()), 32'd0);
    endtask

    // Scoreboard monitor: every grant pulse must match the oldest expected capture.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!spacing_chk) win_n = 0;
        if (grant != 4'b0000) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", {28'd0, grant}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("grant", {28'd0, grant}, 32'(4'b0001 << e.id));
                chk("out_id", {30'd0, out_id}, {30'd0, e.id});
                chk("out_data", {24'd0, out_data}, {24'd0, e.data});
                chk("out_valid_with_grant", {31'd0, out_valid}, 32'd1);
            end
            if (spacing_chk) begin
                if (win_n > 0) chk("grant_spacing", 32'(cyc - last_grant_cyc), 32'd2);
                last_grant_cyc = cyc;
                win_n++;
            end
        end else if (spacing_chk) begin
            chk("valid_one_cycle", {31'd0, out_valid}, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef COMP_CONV_ARB_NZ_FIX_EN
        nz_exp = 8'h00;
`else
        nz_exp = 8'h80;
`endif
        vecs[0] = '{req: 4'b0100, words: 32'h33_85_22_11, id: 2'd2, data: 8'hFB};
        vecs[1] = '{req: 4'b0011, words: 32'h44_55_66_80, id: 2'd0, data: nz_exp};
        vecs[2] = '{req: 4'b1001, words: 32'hFF_03_02_01, id: 2'd3, data: 8'h81};
        vecs[3] = '{req: 4'b1111, words: 32'h12_34_56_7F, id: 2'd0, data: 8'h7F};
        vecs[4] = '{req: 4'b1101, words: 32'h9C_8A_01_02, id: 2'd2, data: 8'hF6};
        vecs[5] = '{req: 4'b0110, words: 32'h77_66_81_55, id: 2'd1, data: 8'hFF};
        vecs[6] = '{req: 4'b1000, words: 32'h00_11_22_33, id: 2'd3, data: 8'h00};
        vecs[7] = '{req: 4'b0010, words: 32'h01_02_C0_03, id: 2'd1, data: 8'hC0};

        // Reset with all requesters active.
        rst_n = 1'b0;
        req = 4'b1111;
        data_in = 32'hA0_B0_C0_05;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_grant", {28'd0, grant}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        chk("rst_out_id", {30'd0, out_id}, 32'd0);
        push(2'd0, 8'h05);
        rst_n = 1'b1;
        wait_sb_empty(10);
        req = 4'b0000;
        @(negedge clk);
        #1;
        chk("handshake_drop", {31'd0, out_valid}, 32'd0);

        // Table vectors, round-robin pointer continues from requester 1.
        for (int v = 0; v < 8; v++) begin
            req = vecs[v].req;
            data_in = vecs[v].words;
            push(vecs[v].id, vecs[v].data);
            wait_sb_empty(10);
            req = 4'b0000;
        end
        @(negedge clk);
        #1;

        // Backpressure: word held, no grant while all request.
        out_ready = 1'b0;
        req = 4'b1111;
        data_in = 32'h84_83_20_10;
        push(2'd2, 8'hFD);
        wait_sb_empty(10);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_data", {24'd0, out_data}, 32'h0000_00FD);
            chk("bp_grant", {28'd0, grant}, 32'd0);
        end
        push(2'd3, 8'hFC);
        out_ready = 1'b1;
        wait_sb_empty(10);
        req = 4'b0000;
        @(negedge clk);
        #1;

        // Reset during HOLD discards the word and restarts at requester 0.
        out_ready = 1'b0;
        req = 4'b0100;
        data_in = 32'h00_05_00_00;
        push(2'd2, 8'h05);
        wait_sb_empty(10);
        req = 4'b0000;
        @(negedge clk);
        #1;
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_data", {24'd0, out_data}, 32'd0);
        @(negedge clk);
        #1;
        req = 4'b1111;
        data_in = 32'h81_FF_7F_00;
        out_ready = 1'b1;
        push(2'd0, 8'h00);
        push(2'd1, 8'h7F);
        push(2'd2, 8'h81);
        push(2'd3, 8'hFF);
        spacing_chk = 1'b1;
        rst_n = 1'b1;
        wait_sb_empty(20);
        spacing_chk = 1'b0;
        req = 4'b0000;
        repeat (3) @(negedge clk);
        #1;
        chk("final_idle_valid", {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/comp_conv_arb.md
# comp_conv_arb

Round-robin arbiter and sequencer that shares a single sign-magnitude to two's-complement conversion datapath among up to N_REQ requesters. Each requester presents a W-bit sign-magnitude word with a level request. The block grants one requester at a time, converts the captured word into a registered output and holds it under a valid/ready handshake. It sits between the sample producers and the arithmetic units that consume two's-complement data.

## Interface
- W, 8, word width; bit W-1 is the sign, bits W-2:0 the magnitude
- N_REQ, 4, number of requesters (2..2^ID_W)
- ID_W, 2, width of requester index
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  level request per requester
- data_in  in  N_REQ*W  requester i word at bits [i*W +: W]
- grant  out  N_REQ  one-hot, one-cycle pulse: word of requester i captured
- out_valid  out  1  out_data/out_id hold a converted word
- out_data  out  W  converted two's-complement word
- out_id  out  ID_W  index of requester that produced out_data
- out_ready  in  1  consumer accepts out_data when high with out_valid

## Operation
- States: IDLE, HOLD. Round-robin pointer ptr (ID_W bits).
- IDLE: on an edge where any req bit is high, the winner is the first set req bit searching ptr, ptr+1, … with wrap at N_REQ-1 -> 0.
  - Winner's data is converted and stored in out_data.
  - out_id is set to the winner index, grant[winner] is set for one cycle, out_valid is set to 1 and the state goes to HOLD.
  - ptr becomes winner+1 mod N_REQ.
- IDLE with req==0: no change. grant is all zero.
- HOLD: req is ignored and out_data/out_id are stable. On an edge with out_ready=1: out_valid->0, state->IDLE. out_data/out_id keep their last value.
- Conversion, for input x:
  - x[W-1]=0: result = x.
  - x[W-1]=1: result = {1, (~x[W-2:0] + 1) mod 2^(W-1)}. The carry out of the magnitude add is discarded.
  - Examples at W=8: 0x05->0x05, 0x85->0xFB, 0xFF->0x81, 0x80->0x80 (negative zero without the macro).
- Requester contract: hold req and data_in stable until it samples its grant bit high. On that same edge it drops req or presents the next word.
- Requests from indices ≥ N_REQ do not exist. Bits of req beyond N_REQ are not present.

## Timing
- Reset (asynchronous assert, synchronous release) sets: grant=0, out_valid=0, out_data=0, out_id=0, ptr=0, state IDLE.
- Reset mid-HOLD discards the held word. No grant is reissued.
- Latency: capture edge E -> out_valid=1 and grant pulse during cycle E..E+1. Combinational path from data_in to out_data: none; the output is registered.
- Handshake completes on the first edge with out_valid=1 and out_ready=1. out_ready=1 held constant gives out_valid high for exactly 1 cycle.
- Minimum spacing between captures is 2 cycles: the capture edge, then the handshake edge, then the next capture at the earliest one edge later.
- Simultaneous requests: exactly one grant per capture, chosen by ptr. No requester waits more than N_REQ-1 other captures.
- Grant is never asserted in HOLD. grant and out_valid rise in the same cycle.

## Configuration
- COMP_CONV_ARB_NZ_FIX_EN defined: input with sign=1 and magnitude 0 (negative zero, 0x80 at W=8) converts to 0x00.
- COMP_CONV_ARB_NZ_FIX_EN undefined: the same input converts to 0x80 per the conversion rule.
- All other inputs are unaffected by the macro.

## Test plan
- Reset with req=4'b1111 held: outputs all 0. After release, first capture grants requester 0 (grant=4'b0001, out_id=0).
- Single requester 2, data 0x85, out_ready=1: grant=4'b0100, then out_valid=1 for 1 cycle with out_data=0xFB, out_id=2. ptr=3.
- All four requesting continuously with out_ready=1: grant order is 0,1,2,3,0… with one grant every 2 cycles. Words 0x00, 0x7F, 0xFF, 0x81 give 0x00, 0x7F, 0x81, 0xFF.
- out_ready=0 for 5 cycles after capture of 0x83: out_valid and out_data=0xFD held stable, no grant while req=4'b1111. Raising out_ready completes the transfer, and the next grant follows.
- Input 0x80: out_data=0x80 without the macro and 0x00 with COMP_CONV_ARB_NZ_FIX_EN.
- rst_n pulled low during HOLD: out_valid drops immediately (asynchronous), ptr=0. After release, the next grant restarts from requester 0.
